// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer for the pipelined MIPS core.
// It checks load/store alignment, runs one outstanding req/ack bus transaction
// and presents the latched read word plus extender controls to writeback.
// Optional feature macro: MEM_TIMEOUT_EN adds a bus timeout and the ERR state.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_en,
    input  logic        st_en,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ext_rdata,
    output logic [1:0]  ext_a,
    output logic [2:0]  ext_op
);

`ifdef MEM_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
`endif

    state_t      state, state_nxt;
    logic        capture;
    logic        misal;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [2:0]  lane_op;
    logic        r_we;
    logic [3:0]  r_be;
    logic [29:0] r_waddr;
    logic [31:0] r_wdata;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  tcnt;
`endif

    // Alignment check and lane steering of the presented instruction
    always_comb begin
        misal      = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
        lane_be    = 4'b1111;
        lane_wdata = wdata;
        lane_op    = 3'b000;
        case (size)
            2'b00: begin
                lane_be    = 4'(4'b0001 << addr[1:0]);
                lane_wdata = {4{wdata[7:0]}};
                lane_op    = sign ? 3'b010 : 3'b001;
            end
            2'b01: begin
                lane_be    = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                lane_op    = sign ? 3'b100 : 3'b011;
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata;
                lane_op    = 3'b000;
            end
        endcase
        // a load reads the whole word; ld_en wins over st_en
        if (ld_en) lane_be = 4'b1111;
    end

    // Next-state and control outputs
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        exc_adel  = 1'b0;
        exc_ades  = 1'b0;
        bus_err   = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld_en || st_en) begin
                    if (misal) begin
                        exc_adel = ld_en;
                        exc_ades = ~ld_en;
                    end else begin
                        stall     = 1'b1;
                        capture   = 1'b1;
                        state_nxt = S_BUS;
                    end
                end
            end
            S_BUS: begin
                bus_req = 1'b1;
                bus_we  = r_we;
                stall   = 1'b1;
                if (bus_ack) begin
                    state_nxt = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tcnt == 8'(TIMEOUT - 1)) begin
                    state_nxt = S_ERR;
                end
`endif
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            S_ERR: begin
                bus_err   = 1'b1;
                state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Capture of the accepted access and extender controls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_waddr <= 30'd0;
            r_wdata <= 32'd0;
            ext_a   <= 2'b00;
            ext_op  <= 3'b000;
        end else if (capture) begin
            r_we    <= ~ld_en;
            r_be    <= lane_be;
            r_waddr <= addr[31:2];
            r_wdata <= lane_wdata;
            ext_a   <= addr[1:0];
            ext_op  <= lane_op;
        end
    end

    // Read word is latched only when a load is acknowledged
    always_ff @(posedge clk) begin
        if (reset) ext_rdata <= 32'd0;
        else if ((state == S_BUS) && bus_ack && !r_we) ext_rdata <= bus_rdata;
    end

`ifdef MEM_TIMEOUT_EN
    // Wait-cycle counter, cleared when a transaction enters BUS
    always_ff @(posedge clk) begin
        if (reset || capture) tcnt <= 8'd0;
        else if ((state == S_BUS) && !bus_ack) tcnt <= tcnt + 8'd1;
    end
`endif

    assign bus_be    = r_be;
    assign bus_addr  = {r_waddr, 2'b00};
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes the expected outcome
// of each access, an independent monitor pops and compares on done/exception.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_en = 1'b0, st_en = 1'b0, sign = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        stall, done, exc_adel, exc_ades, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic [31:0] ext_rdata;
    logic [1:0]  ext_a;
    logic [2:0]  ext_op;

    int errors = 0;
    int checks = 0;

    // kind: 0 load done, 1 store done, 2 adel, 3 ades, 4 bus error
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  a;
        logic [2:0]  op;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_rdata = 32'd0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .st_en(st_en), .size(size),
        .sign(sign), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .ext_rdata(ext_rdata), .ext_a(ext_a), .ext_op(ext_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: tracks bus fields, pops the scoreboard on every reported outcome
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we, prev_req;
    initial begin
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                continue;
            end
            if (bus_req) begin
                if (prev_req) begin
                    chk("bus_addr_stable", bus_addr, seen_addr);
                    chk("bus_be_stable", {28'd0, bus_be}, {28'd0, seen_be});
                end
                seen_addr  = bus_addr;
                seen_be    = bus_be;
                seen_wdata = bus_wdata;
                seen_we    = bus_we;
            end
            prev_req = bus_req;
            if (done || exc_adel || exc_ades || bus_err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: done=%b adel=%b ades=%b err=%b with empty scoreboard",
                             done, exc_adel, exc_ades, bus_err);
                end else begin
                    e = q.pop_front();
                    if (done) begin
                        chk("done_kind", {31'd0, seen_we}, (e.kind == 1) ? 32'd1 : (e.kind == 0) ? 32'd0 : 32'd9);
                        chk("bus_addr", seen_addr, e.addr);
                        chk("bus_be", {28'd0, seen_be}, {28'd0, e.be});
                        if (e.kind == 1) chk("bus_wdata", seen_wdata, e.wdata);
                        chk("ext_rdata", ext_rdata, e.rdata);
                        if (e.kind == 0) begin
                            chk("ext_a", {30'd0, ext_a}, {30'd0, e.a});
                            chk("ext_op", {29'd0, ext_op}, {29'd0, e.op});
                        end
                    end else if (bus_err) begin
                        chk("err_kind", 32'd4, e.kind);
                        chk("err_ext_rdata", ext_rdata, e.rdata);
                    end else begin
                        chk("exc_kind", {30'd0, exc_adel, exc_ades}, (e.kind == 2) ? 32'd2 : (e.kind == 3) ? 32'd1 : 32'd0);
                    end
                end
            end
        end
    end

    // Driver: presents one instruction, answers the bus, pushes the expectation
    task automatic access(input logic l, input logic s, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] rd);
        exp_t e;
        logic mis;
        mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
        ld_en = l; st_en = s; size = sz; sign = sg; addr = a; wdata = wd;
        if (!(l || s)) begin
            @(negedge clk);
            chk("noreq_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        if (mis) begin
            e.kind = l ? 2 : 3;
            q.push_back(e);
            @(negedge clk);
            chk("mis_stall", {31'd0, stall}, 32'd0);
            chk("mis_req", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
            ld_en = 1'b0; st_en = 1'b0;
            @(negedge clk);
            chk("mis_after_req", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        e.kind  = l ? 0 : 1;
        e.addr  = {a[31:2], 2'b00};
        e.be    = l ? 4'hF : (sz == 2'b00) ? 4'(1 << a[1:0]) : (sz == 2'b01) ? (a[1] ? 4'hC : 4'h3) : 4'hF;
        e.wdata = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
        if (l) last_rdata = rd;
        e.rdata = last_rdata;
        e.a     = a[1:0];
        e.op    = sz[1] ? 3'd0 : (sz == 2'b00) ? (sg ? 3'd2 : 3'd1) : (sg ? 3'd4 : 3'd3);
        q.push_back(e);
        @(negedge clk);
        chk("cap_stall", {31'd0, stall}, 32'd1);
        chk("cap_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        for (int w = 0; w <= waits; w++) begin
            bus_ack   = (w == waits);
            bus_rdata = (w == waits) ? rd : $urandom;
            @(negedge clk);
            chk("bus_req", {31'd0, bus_req}, 32'd1);
            chk("bus_stall", {31'd0, stall}, 32'd1);
            chk("bus_we", {31'd0, bus_we}, {31'd0, ~l});
            chk("bus_nodone", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        ld_en = 1'b0; st_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r;
        logic [31:0] ra;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_req_we", {30'd0, bus_req, bus_we}, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_ext_rdata", ext_rdata, 32'd0);
        chk("rst_ext", {27'd0, ext_a, ext_op}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed cases
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80AA_5511);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_BEEF, 3, 32'h0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0, 0, 32'h0);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0305, 32'h0, 0, 32'h0);
        access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 1, 32'hCAFE_F00D);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00A5, 0, 32'h0);
        access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0808, 32'h0, 2, 32'h0123_4567);

        // reset in the second BUS cycle, then a late ack
        ld_en = 1'b1; st_en = 1'b0; size = 2'b10; addr = 32'h0000_0500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; ld_en = 1'b0;
        last_rdata = 32'd0;
        @(negedge clk);
        chk("rstmid_req", {31'd0, bus_req}, 32'd0);
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_done", {31'd0, done}, 32'd0);
        chk("late_ack_req", {31'd0, bus_req}, 32'd0);
        chk("late_ack_rdata", ext_rdata, 32'd0);
        @(posedge clk); #1;

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            r  = 4'($urandom);
            ra = $urandom;
            if (r[3]) ra[1:0] = 2'b00;
            access(r[0], r[1], 2'($urandom), 1'($urandom), ra, $urandom,
                   int'($urandom_range(0, 3)), $urandom);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            exp_t e;
            int   c;
            e.kind  = 4;
            e.rdata = last_rdata;
            q.push_back(e);
            ld_en = 1'b1; size = 2'b10; addr = 32'h0000_0600;
            c = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("to_nodone", {31'd0, done}, 32'd0);
                if (bus_err) begin
                    c = k;
                    break;
                end
            end
            chk("to_err_cycle", c, 32'd5);
            @(posedge clk); #1;
            ld_en = 1'b0;
            @(negedge clk);
            chk("to_req_low", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
        end
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for data-memory accesses in the MEM stage of the pipelined MIPS core. It takes one load or store per instruction and checks address alignment. It then runs a single-outstanding req/ack transaction on the data bus, stalling the pipeline until the transaction completes. For stores it generates byte enables and lane-replicated write data. For loads it latches the raw bus word and drives the extension opcode and byte offset consumed by the load extender in the writeback path.

## Interface
- `TIMEOUT`, default 16: bus cycles without `bus_ack` before abort. Used only when `MEM_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_en` in 1: MEM-stage instruction is a load.
- `st_en` in 1: MEM-stage instruction is a store.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `sign` in 1: load sign-extends; ignored for stores and word loads.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `stall` out 1: hold the pipeline.
- `done` out 1: one-cycle pulse when an access completes.
- `exc_adel` / `exc_ades` out 1: one-cycle misaligned load/store exception pulse.
- `bus_err` out 1: one-cycle timeout pulse. Constant 0 without `MEM_TIMEOUT_EN`.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: write strobe.
- `bus_be` out 4: byte enables.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-aligned store data.
- `bus_ack` in 1: transaction accepted/complete.
- `bus_rdata` in 32: read word, valid with `bus_ack`.
- `ext_rdata` out 32: latched raw read word.
- `ext_a` out 2: latched `addr[1:0]`.
- `ext_op` out 3: extender opcode. 000 = word, 001 = byte zero-ext, 010 = byte sign-ext, 011 = half zero-ext, 100 = half sign-ext.

## Operation
- **States:** IDLE, BUS, DONE, and ERR (ERR only with the macro).
- **IDLE:**
  - Request = `ld_en | st_en`. If both are high, treat it as a load; `st_en` is ignored.
  - Misaligned means: half with `addr[0]` set, or word with `addr[1:0]` nonzero.
  - Misaligned request: pulse `exc_adel` (load) or `exc_ades` (store) combinationally in that cycle. Issue no bus access, keep `stall` = 0, stay in IDLE.
  - Aligned request: `stall` = 1 combinationally. Capture addr, size, sign, we and the aligned data/enables into registers. Go to BUS.
- **BUS:**
  - `bus_req` = 1; all `bus_*` outputs are driven from the captured registers and stay stable until ack. `stall` = 1.
  - On `bus_ack`: if it is a load, latch `bus_rdata` into `ext_rdata`. Go to DONE.
- **DONE:** `done` = 1, `stall` = 0. Inputs are ignored in this cycle (the same instruction is still presented). Next state is IDLE.
- **Byte enables and write data:**
  - Byte: `bus_be` = `4'b0001 << addr[1:0]`, `bus_wdata` = `{4{wdata[7:0]}}`.
  - Half: `bus_be` = `addr[1]` ? 1100 : 0011, `bus_wdata` = `{2{wdata[15:0]}}`.
  - Word: `bus_be` = 1111, `bus_wdata` = `wdata`.
  - Loads drive `bus_be` = 1111 and `bus_we` = 0.
- **Extender outputs:** `ext_op` and `ext_a` are registered at capture and held until the next capture. `ext_rdata` holds until the next load ack.
- **Idle bus:** outside BUS, `bus_req` and `bus_we` = 0. A stray `bus_ack` in any non-BUS state is ignored.

## Timing
- **Reset values:** state = IDLE. All outputs are 0 (`stall`, `done`, exceptions, `bus_err`, `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `ext_rdata`, `ext_a`, `ext_op`).
- **Reset mid-transaction:** `bus_req` drops at the reset edge. No `done` is issued.
- **Minimum latency (ack in the first BUS cycle):**
  - Cycle 0: IDLE, `stall` = 1.
  - Cycle 1: BUS, `bus_req` = 1, ack arrives.
  - Cycle 2: DONE, `done` = 1, `stall` = 0, `ext_rdata` valid.
- **Each wait cycle** (BUS without ack) adds one cycle of latency.
- **Back-to-back accesses:** the earliest next capture is the cycle after DONE.
- **Exception pulses** are combinational on the inputs and are not delayed.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to BUS and increments on each BUS cycle without ack.
  - When it reaches `TIMEOUT` − 1 without ack: go to ERR. `bus_req` drops.
  - ERR lasts one cycle with `bus_err` = 1, `stall` = 0, `done` = 0, then returns to IDLE.
  - On a load abort, `ext_rdata` is unchanged.
- **`MEM_TIMEOUT_EN` undefined:** no counter and no ERR state. BUS waits for ack indefinitely. `bus_err` is tied to 0.

## Test plan
- **Signed byte load:** `lb` at `addr` 0x103, `bus_rdata` 0x80AA5511, ack in the first BUS cycle → `done` at cycle 2, `ext_rdata` = 0x80AA5511, `ext_a` = 3, `ext_op` = 010, `bus_addr` = 0x100.
- **Half store:** `sh` at 0x202 with `wdata` 0x1234BEEF, ack after 3 wait cycles → `bus_be` = 1100, `bus_wdata` = 0xBEEFBEEF, `bus_we` = 1 for 4 BUS cycles, `stall` high 5 cycles, then `done`.
- **Misaligned accesses:** `lw` at 0x301 → `exc_adel` pulse, `bus_req` never asserted, `stall` = 0. `sh` at 0x305 → `exc_ades` pulse, same behaviour.
- **Simultaneous `ld_en`/`st_en`, word size, addr 0x400:** → `bus_we` = 0, `bus_be` = 1111, load completes.
- **Reset mid-transaction:** `reset` asserted in the second BUS cycle → next cycle `bus_req` = 0, `stall` = 0, state IDLE. A late ack produces no `done`.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT` = 4):** no ack → `bus_err` pulse 5 cycles after the request, `done` never asserted, `bus_req` low afterward.
